dram_charram_ctrl: RTL and testbench
====================================

# dram_charram_ctrl

Sequencer and arbiter for one 4416 character-RAM DRAM plane (16K×4, multiplexed 8-bit row / 6-bit column address). Shares the DRAM between the video fetch port (read-only, priority) and the CPU port (read/write, starvation-protected). Generates /RAS, /CAS, /WR and /RD, and returns read data with per-port completion strobes. Optionally inserts RAS-only refresh cycles. Sits between the video timing logic / CPU bus glue and the DRAM plane model.

## Interface
- `CPU_STARVE_MAX`, 4: consecutive video grants allowed while the CPU is pending; the next grant then goes to the CPU.
- `REFRESH_PERIOD`, 128: MCLK cycles between refresh requests (used only with refresh compiled in).
- `i_MCLK` in 1: sole clock; all logic on the posedge.
- `i_RST` in 1: synchronous, active-high reset.
- `i_VID_REQ` in 1: video read request, level; held until `o_VID_VALID`.
- `i_VID_ADDR` in 14: video word address {col[5:0], row[7:0]}.
- `o_VID_DOUT` out 4: video read data.
- `o_VID_VALID` out 1: one-cycle strobe; `o_VID_DOUT` is valid.
- `i_CPU_REQ` in 1: CPU request, level; held until `o_CPU_ACK`.
- `i_CPU_WR` in 1: 1 = write, 0 = read.
- `i_CPU_ADDR` in 14: CPU word address, same format as video.
- `i_CPU_DIN` in 4: CPU write data.
- `o_CPU_DOUT` out 4: CPU read data.
- `o_CPU_ACK` out 1: one-cycle completion strobe (reads and writes).
- `o_ADDR` out 8: multiplexed DRAM address.
- `o_DIN` out 4: DRAM write data.
- `o_RAS_n`, `o_CAS_n`, `o_WR_n`, `o_RD_n` out 1 each: DRAM strobes, active low.
- `i_DOUT` in 4: DRAM read data (registered in the DRAM, one cycle after a `/RD` edge).
- `o_BUSY` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → ROW → COL → XFER → LATCH → PRE → IDLE. Refresh path: IDLE → REF → PRE.
- All DRAM outputs are registered and decoded from the next state, so each value is stable for the whole state.
- IDLE: all strobes high. Arbitrate:
  - Refresh due: refresh wins.
  - Else video and CPU both requesting and starve count = `CPU_STARVE_MAX`: CPU wins.
  - Else video wins over CPU.
  - Else CPU.
- On grant, latch port, address, write flag and write data internally.
- Starve count:
  - Increments (saturating) on each video grant while `i_CPU_REQ` is high.
  - Clears on a CPU grant, and on any IDLE cycle with `i_CPU_REQ` low.
- ROW: `o_RAS_n`=0, `o_CAS_n`=1, `o_ADDR`=addr[7:0].
- COL: `o_RAS_n`=0, `o_CAS_n`=0, `o_ADDR`={1'b0, addr[13:8], 1'b0}.
- XFER: same as COL, plus `o_RD_n`=0 (read) or `o_WR_n`=0 with `o_DIN`=latched data (write).
- LATCH: strobes unchanged except `o_RD_n`/`o_WR_n` back high. At the end of LATCH:
  - Capture `i_DOUT` into the granted port's DOUT register (CPU writes leave `o_CPU_DOUT` unchanged).
  - Set that port's VALID/ACK.
- PRE: all strobes high; VALID/ACK high for this cycle only. PRE always returns to IDLE; there are no back-to-back grants.
- REF: `o_RAS_n`=0, `o_CAS_n`=1, `o_ADDR`=refresh row counter; the counter increments at the end of REF.
- A request dropped before grant is simply not served. Dropping a request after grant does not abort the access.

## Timing
- Access = 6 cycles (IDLE..PRE). Request high at the edge ending IDLE → VALID/ACK visible 5 cycles later (during PRE). Refresh = 3 cycles.
- Requester must deassert REQ at the edge ending PRE; the following IDLE edge then does not re-grant.
- Sustained video-only throughput: 1 read per 6 MCLK.
- Worst-case CPU latency: (`CPU_STARVE_MAX`+1) accesses + 1 refresh.
- Reset values:
  - All strobes = 1.
  - `o_ADDR`, `o_DIN`, `o_VID_DOUT`, `o_CPU_DOUT` = 0.
  - `o_VID_VALID`, `o_CPU_ACK`, `o_BUSY` = 0.
  - State IDLE; starve count, refresh timer and refresh row = 0.
- Reset asserted mid-access: strobes high from the next cycle, and the pending VALID/ACK is discarded.

## Configuration
- `CHARRAM_REFRESH_EN` defined: refresh timer and REF state compiled in. The timer counts MCLK and sets refresh-due at `REFRESH_PERIOD`-1. Due is cleared at REF entry and held while another access is in progress.
- Not defined: no REF state and no timer; arbitration is video/CPU only. `REFRESH_PERIOD` is unused.

## Structure
- Package `charram_ctrl_pkg`:
  - State enum.
  - Address split constants (ROW_W=8, COL_W=6, column field at `o_ADDR[6:1]`).
  - Port-select enum (VID/CPU/REF).
- Sub-module `charram_refresh_timer` (counter, due flag, 8-bit row counter), instantiated only under `CHARRAM_REFRESH_EN`.

## Test plan
- Video read 14'h2A5C with the DRAM preloaded with 4'h9 there: ROW drives 8'h5C, COL drives 8'h54; `o_VID_VALID` 5 cycles after grant with `o_VID_DOUT`=4'h9.
- CPU write 4'hB to 14'h0103, then CPU read of 14'h0103: `/WR` low exactly one cycle; read returns `o_CPU_DOUT`=4'hB with `o_CPU_ACK` one cycle wide.
- Video REQ held continuously with CPU REQ pending: exactly 4 video grants, then 1 CPU grant, repeating.
- Simultaneous video and CPU request from reset: video granted first; CPU ACK 6 cycles after `o_VID_VALID`.
- With `CHARRAM_REFRESH_EN`, `REFRESH_PERIOD`=16, idle ports: REF every 16 cycles with `o_ADDR` = 0, 1, 2, …, and `/CAS` never low.
- `i_RST` pulsed during COL: all strobes high the next cycle, no VALID/ACK, and the next request is served normally.

Source files
------------

// File: rtl/charram_ctrl_pkg.sv
// Shared types and address-split constants for the 4416 character-RAM controller.
package charram_ctrl_pkg;

   localparam int unsigned ROW_W   = 8;
   localparam int unsigned COL_W   = 6;
   localparam int unsigned ADDR_W  = ROW_W + COL_W;
   localparam int unsigned DATA_W  = 4;
   localparam int unsigned COL_LSB = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROW,
      ST_COL,
      ST_XFER,
      ST_LATCH,
      ST_PRE,
      ST_REF
   } state_t;

   typedef enum logic [1:0] {
      PORT_VID,
      PORT_CPU,
      PORT_REF
   } port_t;

   // Column address as presented on the 8-bit DRAM address bus: {1'b0, col, 1'b0}.
   function automatic logic [ROW_W-1:0] col_addr(input logic [ADDR_W-1:0] a);
      return ROW_W'(a[ADDR_W-1:ROW_W]) << COL_LSB;
   endfunction

endpackage

// File: rtl/charram_refresh_timer.sv
// Refresh interval timer, sticky due flag and RAS-only refresh row counter.
module charram_refresh_timer
   import charram_ctrl_pkg::*;
#(
   parameter int unsigned PERIOD = 128
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ref_start,
   input  logic             i_ref_done,
   output logic             o_due,
   output logic [ROW_W-1:0] o_row
);

   localparam int unsigned CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_due;
   logic [ROW_W-1:0] r_row;

   // A new period expiring in the same cycle as a REF grant keeps the flag set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_due <= 1'b0;
         r_row <= '0;
      end else begin
         if (r_cnt == CNT_W'(PERIOD - 1)) begin
            r_cnt <= '0;
            r_due <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (i_ref_start) r_due <= 1'b0;
         end
         if (i_ref_done) r_row <= r_row + ROW_W'(1);
      end
   end

   assign o_due = r_due;
   assign o_row = r_row;

endmodule

// File: rtl/dram_charram_ctrl.sv
// Video/CPU arbiter and /RAS-/CAS sequencer for one 4416 character-RAM plane.
// Define CHARRAM_REFRESH_EN to compile in periodic RAS-only refresh.
module dram_charram_ctrl
   import charram_ctrl_pkg::*;
#(
   parameter int unsigned CPU_STARVE_MAX = 4
`ifdef CHARRAM_REFRESH_EN
   ,parameter int unsigned REFRESH_PERIOD = 128
`endif
)(
   input  logic              i_MCLK,
   input  logic              i_RST,
   input  logic              i_VID_REQ,
   input  logic [ADDR_W-1:0] i_VID_ADDR,
   output logic [DATA_W-1:0] o_VID_DOUT,
   output logic              o_VID_VALID,
   input  logic              i_CPU_REQ,
   input  logic              i_CPU_WR,
   input  logic [ADDR_W-1:0] i_CPU_ADDR,
   input  logic [DATA_W-1:0] i_CPU_DIN,
   output logic [DATA_W-1:0] o_CPU_DOUT,
   output logic              o_CPU_ACK,
   output logic [ROW_W-1:0]  o_ADDR,
   output logic [DATA_W-1:0] o_DIN,
   output logic              o_RAS_n,
   output logic              o_CAS_n,
   output logic              o_WR_n,
   output logic              o_RD_n,
   input  logic [DATA_W-1:0] i_DOUT,
   output logic              o_BUSY
);

   localparam int unsigned STARVE_W = $clog2(CPU_STARVE_MAX + 1);

   state_t              r_state;
   state_t              w_next;
   port_t               r_port;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STARVE_W-1:0] r_starve;
   logic                w_starved;
   logic                w_grant_vid;
   logic                w_grant_cpu;
   logic                w_grant_ref;
   logic [ROW_W-1:0]    w_grant_row;
   logic                w_ref_due;
   logic [ROW_W-1:0]    w_ref_row;

   logic                r_ras_n;
   logic                r_cas_n;
   logic                r_wr_n;
   logic                r_rd_n;
   logic [ROW_W-1:0]    r_dram_addr;
   logic [DATA_W-1:0]   r_din;
   logic [DATA_W-1:0]   r_vid_dout;
   logic                r_vid_valid;
   logic [DATA_W-1:0]   r_cpu_dout;
   logic                r_cpu_ack;
   logic                r_busy;

`ifdef CHARRAM_REFRESH_EN
   charram_refresh_timer #(
      .PERIOD      (REFRESH_PERIOD)
   ) u_refresh (
      .i_clk       (i_MCLK),
      .i_rst       (i_RST),
      .i_ref_start (w_grant_ref),
      .i_ref_done  (r_state == ST_REF),
      .o_due       (w_ref_due),
      .o_row       (w_ref_row)
   );
`else
   assign w_ref_due = 1'b0;
   assign w_ref_row = '0;
`endif

   assign w_starved   = (r_starve == STARVE_W'(CPU_STARVE_MAX));
   assign w_grant_row = w_grant_vid ? i_VID_ADDR[ROW_W-1:0] : i_CPU_ADDR[ROW_W-1:0];

   always_ff @(posedge i_MCLK) begin
      if (i_RST) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Arbitration in IDLE, fixed walk through the access otherwise.
   always_comb begin
      w_next      = r_state;
      w_grant_vid = 1'b0;
      w_grant_cpu = 1'b0;
      w_grant_ref = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ref_due) begin
               w_grant_ref = 1'b1;
               w_next      = ST_REF;
            end else if (i_VID_REQ && i_CPU_REQ && w_starved) begin
               w_grant_cpu = 1'b1;
               w_next      = ST_ROW;
            end else if (i_VID_REQ) begin
               w_grant_vid = 1'b1;
               w_next      = ST_ROW;
            end else if (i_CPU_REQ) begin
               w_grant_cpu = 1'b1;
               w_next      = ST_ROW;
            end
         end
         ST_ROW:   w_next = ST_COL;
         ST_COL:   w_next = ST_XFER;
         ST_XFER:  w_next = ST_LATCH;
         ST_LATCH: w_next = ST_PRE;
         ST_PRE:   w_next = ST_IDLE;
         ST_REF:   w_next = ST_PRE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Request latch and starvation counter.
   always_ff @(posedge i_MCLK) begin
      if (i_RST) begin
         r_port   <= PORT_VID;
         r_addr   <= '0;
         r_wr     <= 1'b0;
         r_wdata  <= '0;
         r_starve <= '0;
      end else begin
         if (w_grant_vid || w_grant_cpu) begin
            r_port  <= w_grant_vid ? PORT_VID : PORT_CPU;
            r_addr  <= w_grant_vid ? i_VID_ADDR : i_CPU_ADDR;
            r_wr    <= w_grant_cpu & i_CPU_WR;
            r_wdata <= i_CPU_DIN;
         end else if (w_grant_ref) begin
            r_port  <= PORT_REF;
         end

         if (w_grant_cpu)
            r_starve <= '0;
         else if (w_grant_vid && i_CPU_REQ && !w_starved)
            r_starve <= r_starve + STARVE_W'(1);
         else if (r_state == ST_IDLE && !i_CPU_REQ)
            r_starve <= '0;
      end
   end

   // DRAM pins decoded from the next state so each value spans its whole state.
   always_ff @(posedge i_MCLK) begin
      if (i_RST) begin
         r_ras_n     <= 1'b1;
         r_cas_n     <= 1'b1;
         r_wr_n      <= 1'b1;
         r_rd_n      <= 1'b1;
         r_dram_addr <= '0;
         r_din       <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_busy <= (w_next != ST_IDLE);
         r_wr_n <= 1'b1;
         r_rd_n <= 1'b1;
         case (w_next)
            ST_ROW: begin
               r_ras_n     <= 1'b0;
               r_cas_n     <= 1'b1;
               r_dram_addr <= w_grant_row;
            end
            ST_COL: begin
               r_ras_n     <= 1'b0;
               r_cas_n     <= 1'b0;
               r_dram_addr <= col_addr(r_addr);
            end
            ST_XFER: begin
               r_ras_n <= 1'b0;
               r_cas_n <= 1'b0;
               r_rd_n  <= r_wr;
               r_wr_n  <= ~r_wr;
               if (r_wr) r_din <= r_wdata;
            end
            ST_LATCH: begin
               r_ras_n <= 1'b0;
               r_cas_n <= 1'b0;
            end
            ST_REF: begin
               r_ras_n     <= 1'b0;
               r_cas_n     <= 1'b1;
               r_dram_addr <= w_ref_row;
            end
            default: begin
               r_ras_n <= 1'b1;
               r_cas_n <= 1'b1;
            end
         endcase
      end
   end

   // Read data capture and one-cycle completion strobes, visible during PRE.
   always_ff @(posedge i_MCLK) begin
      if (i_RST) begin
         r_vid_dout  <= '0;
         r_vid_valid <= 1'b0;
         r_cpu_dout  <= '0;
         r_cpu_ack   <= 1'b0;
      end else begin
         r_vid_valid <= 1'b0;
         r_cpu_ack   <= 1'b0;
         if (r_state == ST_LATCH) begin
            if (r_port == PORT_VID) begin
               r_vid_dout  <= i_DOUT;
               r_vid_valid <= 1'b1;
            end else if (r_port == PORT_CPU) begin
               if (!r_wr) r_cpu_dout <= i_DOUT;
               r_cpu_ack <= 1'b1;
            end
         end
      end
   end

   assign o_RAS_n     = r_ras_n;
   assign o_CAS_n     = r_cas_n;
   assign o_WR_n      = r_wr_n;
   assign o_RD_n      = r_rd_n;
   assign o_ADDR      = r_dram_addr;
   assign o_DIN       = r_din;
   assign o_VID_DOUT  = r_vid_dout;
   assign o_VID_VALID = r_vid_valid;
   assign o_CPU_DOUT  = r_cpu_dout;
   assign o_CPU_ACK   = r_cpu_ack;
   assign o_BUSY      = r_busy;

endmodule

// File: tb/tb_dram_charram_ctrl.sv
// Directed bench for dram_charram_ctrl with a behavioural 4416 plane model.
// With CHARRAM_REFRESH_EN defined only the refresh sequence is exercised.
module tb_dram_charram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        vid_req;
   logic [13:0] vid_addr;
   logic [3:0]  vid_dout;
   logic        vid_valid;
   logic        cpu_req;
   logic        cpu_wr;
   logic [13:0] cpu_addr;
   logic [3:0]  cpu_din;
   logic [3:0]  cpu_dout;
   logic        cpu_ack;
   logic [7:0]  dram_addr;
   logic [3:0]  dram_din;
   logic        ras_n, cas_n, wr_n, rd_n;
   logic [3:0]  dram_dout = 4'h0;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dram_charram_ctrl #(
      .CPU_STARVE_MAX (4)
`ifdef CHARRAM_REFRESH_EN
      ,.REFRESH_PERIOD(16)
`endif
   ) dut (
      .i_MCLK      (clk),
      .i_RST       (rst),
      .i_VID_REQ   (vid_req),
      .i_VID_ADDR  (vid_addr),
      .o_VID_DOUT  (vid_dout),
      .o_VID_VALID (vid_valid),
      .i_CPU_REQ   (cpu_req),
      .i_CPU_WR    (cpu_wr),
      .i_CPU_ADDR  (cpu_addr),
      .i_CPU_DIN   (cpu_din),
      .o_CPU_DOUT  (cpu_dout),
      .o_CPU_ACK   (cpu_ack),
      .o_ADDR      (dram_addr),
      .o_DIN       (dram_din),
      .o_RAS_n     (ras_n),
      .o_CAS_n     (cas_n),
      .o_WR_n      (wr_n),
      .o_RD_n      (rd_n),
      .i_DOUT      (dram_dout),
      .o_BUSY      (busy)
   );

   // 4416 plane: row on /RAS fall, column on /CAS fall, registered read data.
   logic [3:0] mem [0:16383];
   logic [7:0] m_row = 8'h00;
   logic [5:0] m_col = 6'h00;
   logic       m_ras_q = 1'b1;
   logic       m_cas_q = 1'b1;

   always @(posedge clk) begin
      if (!ras_n && m_ras_q) m_row <= dram_addr;
      if (!cas_n && m_cas_q) m_col <= dram_addr[6:1];
      if (!ras_n && !cas_n && !wr_n) mem[{m_col, m_row}] <= dram_din;
      if (!rd_n) dram_dout <= mem[{m_col, m_row}];
      m_ras_q <= ras_n;
      m_cas_q <= cas_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ticks until the selected port completes; cyc is -1 if it never does.
   task automatic wait_done(input bit want_vid, output int cyc, output int wr_low);
      cyc    = 0;
      wr_low = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cyc++;
         if (!wr_n) wr_low++;
         if (want_vid ? vid_valid : cpu_ack) return;
      end
      cyc = -1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int    cyc, wr_low, tv, tc, strobes, last_ref, n_ref, cas_low;
      bit    rearm;
      string seq;

      for (int i = 0; i < 16384; i++) mem[i] = 4'h0;
      mem[14'h2A5C] = 4'h9;

      rst = 1'b1; vid_req = 1'b0; vid_addr = 14'h0000;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 14'h0000; cpu_din = 4'h0;
      tick();
      tick();
      chk("rst_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
      chk("rst_addr", {dram_addr, dram_din}, 12'h000);
      chk("rst_douts", {vid_dout, cpu_dout}, 8'h00);
      chk("rst_flags", {vid_valid, cpu_ack, busy}, 3'b000);
      rst = 1'b0;

`ifdef CHARRAM_REFRESH_EN
      last_ref = -1; n_ref = 0; cas_low = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (!cas_n) cas_low++;
         if (!ras_n && m_ras_q) begin
            chk("ref_row", dram_addr, n_ref);
            if (last_ref >= 0) chk("ref_interval", i - last_ref, 16);
            else               chk("ref_first", i, 17);
            last_ref = i;
            n_ref++;
         end
      end
      chk("ref_count", n_ref, 3);
      chk("ref_cas_never_low", cas_low, 0);
`else
      // Video read of preloaded location, stepped state by state.
      vid_req = 1'b1; vid_addr = 14'h2A5C;
      tick();
      chk("row_strobes", {ras_n, cas_n, busy}, 3'b011);
      chk("row_addr", dram_addr, 8'h5C);
      tick();
      chk("col_strobes", {ras_n, cas_n}, 2'b00);
      chk("col_addr", dram_addr, 8'h54);
      tick();
      chk("xfer_rd", {rd_n, wr_n}, 2'b01);
      tick();
      chk("latch_strobes", {ras_n, cas_n, rd_n, vid_valid}, 4'b0010);
      tick();
      chk("pre_valid", {vid_valid, ras_n, cas_n}, 3'b111);
      chk("pre_vid_dout", vid_dout, 4'h9);
      vid_req = 1'b0;
      tick();
      chk("idle_after", {vid_valid, busy}, 2'b00);
      tick();
      chk("no_regrant", busy, 1'b0);

      // CPU write then read back.
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0103; cpu_din = 4'hB;
      wait_done(1'b0, cyc, wr_low);
      cpu_req = 1'b0;
      chk("wr_latency", cyc, 5);
      chk("wr_low_cycles", wr_low, 1);
      chk("wr_dout_kept", cpu_dout, 4'h0);
      tick();
      cpu_req = 1'b1; cpu_wr = 1'b0;
      wait_done(1'b0, cyc, wr_low);
      cpu_req = 1'b0;
      chk("rd_latency", cyc, 5);
      chk("rd_data", cpu_dout, 4'hB);
      chk("rd_no_wr", wr_low, 0);
      tick();
      chk("ack_one_cycle", cpu_ack, 1'b0);
      tick();

      // Continuous video with CPU pending: four video grants then one CPU.
      seq = ""; rearm = 1'b0;
      vid_req = 1'b1; vid_addr = 14'h2A5C;
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0103;
      for (int i = 0; i < 100 && seq.len() < 10; i++) begin
         tick();
         if (rearm) begin
            cpu_req = 1'b1;
            rearm   = 1'b0;
         end
         if (vid_valid) seq = {seq, "V"};
         if (cpu_ack) begin
            seq = {seq, "C"};
            chk("starve_cpu_data", cpu_dout, 4'hB);
            cpu_req = 1'b0;
            rearm   = 1'b1;
         end
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      n_cmp++;
      assert (seq == "VVVVCVVVVC") else begin
         n_bad++;
         $error("FAIL starve_seq: observed %s expected VVVVCVVVVC", seq);
      end
      tick();
      tick();

      // Simultaneous requests straight out of reset.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vid_req = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0;
      tv = -1; tc = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (vid_valid) begin
            tv      = i;
            vid_req = 1'b0;
         end
         if (cpu_ack) begin
            tc      = i;
            cpu_req = 1'b0;
            break;
         end
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      chk("sim_vid_first", tv, 5);
      chk("sim_cpu_after", tc, 11);
      tick();

      // Reset pulse during COL aborts the access cleanly.
      vid_req = 1'b1; vid_addr = 14'h2A5C;
      tick();
      tick();
      chk("abort_in_col", {ras_n, cas_n}, 2'b00);
      rst = 1'b1; vid_req = 1'b0;
      tick();
      chk("abort_strobes", {ras_n, cas_n, wr_n, rd_n}, 4'hF);
      chk("abort_busy", busy, 1'b0);
      rst = 1'b0;
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (vid_valid || cpu_ack) strobes++;
      end
      chk("abort_no_strobe", strobes, 0);
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0103;
      wait_done(1'b0, cyc, wr_low);
      cpu_req = 1'b0;
      chk("post_abort_latency", cyc, 5);
      chk("post_abort_data", cpu_dout, 4'hB);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
